// File: rtl/reg_bank_pkg.sv
// Shared register-file constants and types, also used by decode and write-back.
package reg_bank_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = 4;

    // Register index and data word as seen by the rest of the core.
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] data_word_t;

endpackage : reg_bank_pkg

// File: rtl/reg_read_port.sv
// One combinational read port: storage lookup, write-through bypass,
// same-cycle hazard clearing and hard-wired zero register handling.
import reg_bank_pkg::*;

module reg_read_port #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_R0  = 1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             pend_vec,
    input  logic [ADDR_W-1:0]               raddr,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               waddr,
    input  logic [DATA_W-1:0]               wdata,
    output logic [DATA_W-1:0]               rdata,
    output logic                            pend
);

    logic bypass_hit;

    // Select stored or in-flight write data; a write landing this cycle
    // resolves the hazard, and R0 overrides everything when hard-wired.
    always_comb begin
        bypass_hit = we && (waddr == raddr);
        rdata      = bypass_hit ? wdata : regs[raddr];
        pend       = pend_vec[raddr] & ~bypass_hit;
        if ((ZERO_R0 != 0) && (raddr == '0)) begin
            rdata = '0;
            pend  = 1'b0;
        end
    end

endmodule : reg_read_port

// File: rtl/reg_bank.sv
// Architectural register file with pending-write scoreboard.
// Storage and scoreboard flops live here; read muxing is in reg_read_port.
import reg_bank_pkg::*;

module reg_bank #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_R0  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    input  logic                lock_en,
    input  logic [ADDR_W-1:0]   lock_addr,
    output logic                pend1,
    output logic                pend2,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_all;
    logic [NUM_REGS-1:0]             pend_all;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if ((ZERO_R0 != 0) && (gi == 0)) begin : g_zero
                // Hard-wired zero register: no storage, never pending.
                assign regs_all[gi] = '0;
                assign pend_all[gi] = 1'b0;
            end else begin : g_store
                logic [DATA_W-1:0] word_reg;
                logic              pend_reg;

                // Data word: captured from write-back when addressed.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        word_reg <= '0;
                    end else if (we && (waddr == ADDR_W'(gi))) begin
                        word_reg <= wdata;
                    end
                end

                // Pending bit: lock from decode takes priority over a
                // same-cycle write-back, since the lock is the newer producer.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pend_reg <= 1'b0;
                    end else if (lock_en && (lock_addr == ADDR_W'(gi))) begin
                        pend_reg <= 1'b1;
                    end else if (we && (waddr == ADDR_W'(gi))) begin
                        pend_reg <= 1'b0;
                    end
                end

                assign regs_all[gi] = word_reg;
                assign pend_all[gi] = pend_reg;
            end
        end
    endgenerate

    assign pend_vec = pend_all;

    reg_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_port1 (
        .regs    (regs_all),
        .pend_vec(pend_all),
        .raddr   (raddr1),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata   (rdata1),
        .pend    (pend1)
    );

    reg_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_port2 (
        .regs    (regs_all),
        .pend_vec(pend_all),
        .raddr   (raddr2),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata   (rdata2),
        .pend    (pend2)
    );

endmodule : reg_bank
